fetch_stage: RTL and testbench

- Instruction fetch stage; sits directly upstream of the instruction BRAM (inst_mem) and downstream consumer is decode.
- Holds the PC and drives the BRAM read port (word address, read_enable).
- Pairs each returned word with its PC.
- Presents {pc, inst} to decode over a valid/ready handshake; accepts branch/jump redirects from execute.

---
 rtl/fetch_stage_pkg.sv | 23 ++
 rtl/fetch_stage_if.sv | 30 +++
 rtl/fetch_perf_counter.sv | 28 ++
 rtl/fetch_stage.sv | 83 ++++++++
 tb/tb_fetch_stage.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_stage_pkg;

  localparam int          PKG_INST_W = 32;
  localparam logic [31:0] INST_BYTES = 32'd4;

  typedef struct packed {
    logic                  valid;
    logic [31:0]           pc;
    logic [PKG_INST_W-1:0] inst;
  } fetch_out_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
  } redirect_t;

  // Word-align a byte address; the low two bits of a target are ignored.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - redirect, instruction-memory and decode-side signals of the fetch stage
interface fetch_stage_if #(
  parameter int INST_W = 32
);

  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              imem_read_enable;
  logic [31:0]       imem_read_addr;
  logic [INST_W-1:0] imem_read_data;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_pc;
  logic [INST_W-1:0] out_inst;
  logic [31:0]       perf_fetched;
  logic [31:0]       perf_stall;

  modport master (
    input  redirect_valid, redirect_pc, imem_read_data, out_ready,
    output imem_read_enable, imem_read_addr, out_valid, out_pc, out_inst,
           perf_fetched, perf_stall
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_read_data, out_ready,
    input  imem_read_enable, imem_read_addr, out_valid, out_pc, out_inst,
           perf_fetched, perf_stall
  );

endinterface

// File: rtl/fetch_perf_counter.sv
// rtl/fetch_perf_counter.sv - delivered-instruction and stall-cycle counters, wrap on overflow
module fetch_perf_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_fetched_i,
  input  logic        inc_stall_i,
  output logic [31:0] fetched_o,
  output logic [31:0] stall_o
);

  logic [31:0] fetched_q;
  logic [31:0] stall_q;

  // Each counter bumps by one on its enable; reset clears both immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetched_q <= 32'd0;
      stall_q   <= 32'd0;
    end else begin
      if (inc_fetched_i) fetched_q <= fetched_q + 32'd1;
      if (inc_stall_i)   stall_q   <= stall_q + 32'd1;
    end
  end

  assign fetched_o = fetched_q;
  assign stall_o   = stall_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC holder and BRAM read driver pairing each word with its PC; perf counters under FETCH_PERF_COUNTERS_EN
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          INST_W   = 32
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master fetch_if
);

  logic [31:0]       issue_pc_q, issue_pc_d;
  logic [31:0]       f2_pc_q, f2_pc_d;
  logic              f2_valid_q, f2_valid_d;
  redirect_t         redir;
  logic              advance;
  logic              out_valid;
  logic [INST_W-1:0] inst_word;

  assign redir.valid = fetch_if.redirect_valid;
  assign redir.pc    = align_pc(fetch_if.redirect_pc);

  // The held slot may move on when it is empty or decode is taking it.
  assign advance   = ~f2_valid_q | fetch_if.out_ready;
  // A redirect squashes whatever sits on the output this cycle.
  assign out_valid = f2_valid_q & ~redir.valid;

  // Next-state: redirect beats everything, otherwise advance or hold for a stall.
  always_comb begin
    issue_pc_d = issue_pc_q;
    f2_pc_d    = f2_pc_q;
    f2_valid_d = f2_valid_q;
    if (redir.valid) begin
      f2_pc_d    = redir.pc;
      f2_valid_d = 1'b1;
      issue_pc_d = redir.pc + INST_BYTES;
    end else if (advance) begin
      f2_pc_d    = issue_pc_q;
      f2_valid_d = 1'b1;
      issue_pc_d = issue_pc_q + INST_BYTES;
    end
  end

  // PC state; reset drops any in-flight read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_pc_q <= RESET_PC;
      f2_pc_q    <= 32'd0;
      f2_valid_q <= 1'b0;
    end else begin
      issue_pc_q <= issue_pc_d;
      f2_pc_q    <= f2_pc_d;
      f2_valid_q <= f2_valid_d;
    end
  end

  // Read port: keep the BRAM output frozen during a stall by not enabling it.
  assign fetch_if.imem_read_enable = ~rst & (redir.valid | advance);
  assign fetch_if.imem_read_addr   = rst         ? (RESET_PC >> 2) :
                                     redir.valid ? {2'b00, redir.pc[31:2]} :
                                                   {2'b00, issue_pc_q[31:2]};

  assign inst_word          = fetch_if.imem_read_data;
  assign fetch_if.out_valid = out_valid;
  assign fetch_if.out_pc    = f2_pc_q;
  assign fetch_if.out_inst  = inst_word;

`ifdef FETCH_PERF_COUNTERS_EN
  fetch_perf_counter u_perf (
    .clk           (clk),
    .rst           (rst),
    .inc_fetched_i (out_valid & fetch_if.out_ready),
    .inc_stall_i   (out_valid & ~fetch_if.out_ready),
    .fetched_o     (fetch_if.perf_fetched),
    .stall_o       (fetch_if.perf_stall)
  );
`else
  assign fetch_if.perf_fetched = 32'd0;
  assign fetch_if.perf_stall   = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed scoreboard bench for fetch_stage
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] rdata_q = 32'd0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_fetched = 32'd0;
  logic [31:0] exp_stall = 32'd0;
  fetch_out_t  sb[$];

  fetch_stage_if #(.INST_W(32)) bus ();

  fetch_stage #(.RESET_PC(32'h0000_0000), .INST_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .fetch_if (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] waddr);
    case (waddr)
      32'd0:   return 32'h11;
      32'd1:   return 32'h22;
      32'd2:   return 32'h33;
      32'd3:   return 32'h44;
      default: return waddr ^ 32'hC0DE_0000;
    endcase
  endfunction

  always @(posedge clk) begin
    if (bus.imem_read_enable) rdata_q <= word_of(bus.imem_read_addr);
  end
  assign bus.imem_read_data = rdata_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc);
    fetch_out_t e;
    e.valid = 1'b1;
    e.pc    = pc;
    e.inst  = word_of(pc >> 2);
    sb.push_back(e);
  endtask

  task automatic chk_perf();
`ifdef FETCH_PERF_COUNTERS_EN
    chk("perf_fetched", bus.perf_fetched, exp_fetched);
    chk("perf_stall", bus.perf_stall, exp_stall);
`else
    chk("perf_fetched_tied", bus.perf_fetched, 32'd0);
    chk("perf_stall_tied", bus.perf_stall, 32'd0);
`endif
  endtask

  // One clock cycle: sample at negedge, compare against scoreboard, then step past the posedge.
  task automatic cyc(input logic exp_valid);
    fetch_out_t e;
    @(negedge clk);
    chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
    if (exp_valid) begin
      if (sb.size() == 0) begin
        chk("scoreboard_empty", 32'(sb.size()), 32'd1);
      end else begin
        e = sb[0];
        chk("out_pc", bus.out_pc, e.pc);
        chk("out_inst", bus.out_inst, e.inst);
        if (bus.out_ready) sb.delete(0);
      end
    end
    chk_perf();
    if (exp_valid && bus.out_ready)  exp_fetched = exp_fetched + 32'd1;
    if (exp_valid && !bus.out_ready) exp_stall   = exp_stall + 32'd1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    bus.out_ready      = 1'b1;

    @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_read_enable", 32'(bus.imem_read_enable), 32'd0);
    chk("rst_read_addr", bus.imem_read_addr, 32'd0);
    chk_perf();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Straight-line fetch from RESET_PC
    push(32'h0); push(32'h4);
    #1;
    chk("first_read_enable", 32'(bus.imem_read_enable), 32'd1);
    chk("first_read_addr", bus.imem_read_addr, 32'd0);
    cyc(1'b0);
    cyc(1'b1);

    // Stall for three cycles on pc=4
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_read_enable", 32'(bus.imem_read_enable), 32'd0);
      cyc(1'b1);
    end
    bus.out_ready = 1'b1;
    push(32'h8);
    cyc(1'b1);

    // pc=8 presented, then redirect to 0x40 squashes it
    bus.out_ready = 1'b0;
    cyc(1'b1);
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    sb.delete(0);
    push(32'h40); push(32'h44);
    #1;
    chk("redir_read_addr", bus.imem_read_addr, 32'h10);
    chk("redir_read_enable", 32'(bus.imem_read_enable), 32'd1);
    cyc(1'b0);
    bus.redirect_valid = 1'b0;
    cyc(1'b1);
    cyc(1'b1);

    // Misaligned redirect during a stall
    bus.out_ready = 1'b0;
    push(32'h48);
    cyc(1'b1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h43;
    sb.delete(0);
    push(32'h40);
    #1;
    chk("misal_read_addr", bus.imem_read_addr, 32'h10);
    chk("misal_read_enable", 32'(bus.imem_read_enable), 32'd1);
    cyc(1'b0);
    bus.redirect_valid = 1'b0;
    #1;
    chk("misal_issue_addr", bus.imem_read_addr, 32'h11);
    chk("misal_stall_enable", 32'(bus.imem_read_enable), 32'd0);
    cyc(1'b1);
    bus.out_ready = 1'b1;
    push(32'h44);
    cyc(1'b1);

    // Wrap from the top of the address space
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    sb.delete(0);
    push(32'hFFFF_FFFC); push(32'h0);
    #1;
    chk("wrap_read_addr", bus.imem_read_addr, 32'h3FFF_FFFF);
    cyc(1'b0);
    bus.redirect_valid = 1'b0;
    cyc(1'b1);
    cyc(1'b1);

    // Async reset in the middle of a stall
    bus.out_ready = 1'b0;
    push(32'h4);
    cyc(1'b1);
    #3;
    rst = 1'b1;
    #1;
    chk("async_out_valid", 32'(bus.out_valid), 32'd0);
    chk("async_read_enable", 32'(bus.imem_read_enable), 32'd0);
    chk("async_read_addr", bus.imem_read_addr, 32'd0);
    exp_fetched = 32'd0;
    exp_stall   = 32'd0;
    sb.delete();
    chk_perf();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    push(32'h0); push(32'h4);
    #1;
    chk("restart_read_addr", bus.imem_read_addr, 32'd0);
    chk("restart_read_enable", 32'(bus.imem_read_enable), 32'd1);
    cyc(1'b0);
    cyc(1'b1);
    cyc(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
